// File: rtl/demux_4_32_buf_pkg.sv
// Shared constants and helpers for the 4-way buffered demultiplexer.
package demux_4_32_buf_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 2;
    localparam int N_CH          = 4;
    localparam int SEL_W         = 2;

    // One-hot destination mask for a channel index.
    function automatic logic [N_CH-1:0] chan_decode(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_4_32_buf_chan_fifo.sv
// Per-channel FIFO: DEPTH words, power-of-two depth so the pointers wrap
// naturally. Only control state is reset; the storage array is not.
module demux_chan_fifo
    import demux_4_32_buf_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; a push into a full FIFO or a pop
    // from an empty one is dropped here so the count can never leave 0..DEPTH.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset wins over any push or pop in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until the count says otherwise.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/demux_4_32_buf.sv
// Buffered 1-to-4 demultiplexer: each accepted word goes into the FIFO of
// the selected channel; each channel drains independently through its own
// valid/ready handshake. DEPTH must be a power of two, at least 2.
module demux_4_32_buf
    import demux_4_32_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       select,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_0,
    output logic [WIDTH-1:0] data_1,
    output logic [WIDTH-1:0] data_2,
    output logic [WIDTH-1:0] data_3,
    output logic             valid_0,
    output logic             valid_1,
    output logic             valid_2,
    output logic             valid_3,
    input  logic             ready_0,
    input  logic             ready_1,
    input  logic             ready_2,
    input  logic             ready_3
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [N_CH-1:0]  ready_w;
    logic [N_CH-1:0]  push_w;
    logic [N_CH-1:0]  pop_w;
    logic [N_CH-1:0]  full_w;
    logic [N_CH-1:0]  empty_w;
    logic [N_CH-1:0]  valid_w;
    logic [WIDTH-1:0] head_w  [N_CH];
    logic [WIDTH-1:0] data_w  [N_CH];
    logic [CNT_W-1:0] count_w [N_CH];

    assign ready_w = {ready_3, ready_2, ready_1, ready_0};

    // Accept decision depends only on registered occupancy, never on ready_k.
    // Held low during reset so nothing is offered as accepted in that cycle.
    always_comb begin
        in_ready = enable & ~reset & ~full_w[select];
        push_w   = (in_valid & in_ready) ? chan_decode(select) : '0;
        pop_w    = valid_w & ready_w;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push_w[k]),
            .push_data (data_in),
            .pop       (pop_w[k]),
            .count     (count_w[k]),
            .head      (head_w[k]),
            .full      (full_w[k]),
            .empty     (empty_w[k])
        );

        // Head word is forced to zero whenever the channel is empty.
        assign valid_w[k] = (count_w[k] != '0);
        assign data_w[k]  = empty_w[k] ? '0 : head_w[k];
    end

    assign data_0  = data_w[0];
    assign data_1  = data_w[1];
    assign data_2  = data_w[2];
    assign data_3  = data_w[3];
    assign valid_0 = valid_w[0];
    assign valid_1 = valid_w[1];
    assign valid_2 = valid_w[2];
    assign valid_3 = valid_w[3];

endmodule

// File: tb/tb_demux_4_32_buf.sv
// Directed and randomized bench for demux_4_32_buf (WIDTH=32, DEPTH=2).
module tb_demux_4_32_buf;

    logic        clock;
    logic        reset;
    logic [31:0] data_in;
    logic [1:0]  select;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_0, data_1, data_2, data_3;
    logic        valid_0, valid_1, valid_2, valid_3;
    logic        ready_0, ready_1, ready_2, ready_3;

    int n_cmp;
    int n_err;

    logic [31:0] dout [4];
    logic [3:0]  vout;

    assign dout[0] = data_0;
    assign dout[1] = data_1;
    assign dout[2] = data_2;
    assign dout[3] = data_3;
    assign vout    = {valid_3, valid_2, valid_1, valid_0};

    demux_4_32_buf dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .select   (select),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_0   (data_0),
        .data_1   (data_1),
        .data_2   (data_2),
        .data_3   (data_3),
        .valid_0  (valid_0),
        .valid_1  (valid_1),
        .valid_2  (valid_2),
        .valid_3  (valid_3),
        .ready_0  (ready_0),
        .ready_1  (ready_1),
        .ready_2  (ready_2),
        .ready_3  (ready_3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        data_in  = '0;
        select   = 2'd0;
        enable   = 1'b1;
        {ready_3, ready_2, ready_1, ready_0} = 4'b0000;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (vout !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0000", vout);
        end
        n_cmp++;
        if ((data_0 | data_1 | data_2 | data_3) !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", data_0, data_1, data_2, data_3);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
        enable = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_in_ready_en0: got %b want 0", in_ready);
        end
        enable = 1'b1;
    endtask

    task automatic test_single_push();
        apply_reset();
        data_in  = 32'hA5A5_0001;
        select   = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in  = '0;
        #1;
        n_cmp++;
        if (vout !== 4'b0100) begin
            n_err++;
            $display("FAIL single_valid: got %b want 0100", vout);
        end
        n_cmp++;
        if (data_2 !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL single_data2: got %h want a5a50001", data_2);
        end
        n_cmp++;
        if ((data_0 | data_1 | data_3) !== 32'h0) begin
            n_err++;
            $display("FAIL single_other_data: got %h %h %h want zeros", data_0, data_1, data_3);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        select   = 2'd1;
        in_valid = 1'b1;
        data_in  = 32'h1111_0001;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_w1: got %b want 1", in_ready);
        end
        tick();
        data_in = 32'h1111_0002;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_w2: got %b want 1", in_ready);
        end
        tick();
        data_in = 32'h1111_0003;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready_full: got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (data_1 !== 32'h1111_0001) begin
            n_err++;
            $display("FAIL bp_head1: got %h want 11110001", data_1);
        end
        ready_1 = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready_pop_cycle: got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_return: got %b want 1", in_ready);
        end
        n_cmp++;
        if (data_1 !== 32'h1111_0002) begin
            n_err++;
            $display("FAIL bp_head2: got %h want 11110002", data_1);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (data_1 !== 32'h1111_0003 || valid_1 !== 1'b1) begin
            n_err++;
            $display("FAIL bp_head3: got %h/%b want 11110003/1", data_1, valid_1);
        end
        tick();
        ready_1 = 1'b0;
        n_cmp++;
        if (valid_1 !== 1'b0 || data_1 !== 32'h0) begin
            n_err++;
            $display("FAIL bp_drained: got %b/%h want 0/0", valid_1, data_1);
        end
    endtask

    task automatic test_push_pop_same();
        apply_reset();
        select   = 2'd0;
        in_valid = 1'b1;
        data_in  = 32'hCAFE_0000;
        tick();
        data_in = 32'hCAFE_0001;
        ready_0 = 1'b1;
        n_cmp++;
        if (data_0 !== 32'hCAFE_0000) begin
            n_err++;
            $display("FAIL pp_head_before: got %h want cafe0000", data_0);
        end
        tick();
        in_valid = 1'b0;
        ready_0  = 1'b0;
        n_cmp++;
        if (valid_0 !== 1'b1 || data_0 !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL pp_head_after: got %b/%h want 1/cafe0001", valid_0, data_0);
        end
        ready_0 = 1'b1;
        tick();
        ready_0 = 1'b0;
        n_cmp++;
        if (valid_0 !== 1'b0) begin
            n_err++;
            $display("FAIL pp_count_one: got valid %b want 0 after one pop", valid_0);
        end
    endtask

    task automatic test_enable_low();
        apply_reset();
        select   = 2'd3;
        in_valid = 1'b1;
        data_in  = 32'h3333_0001;
        tick();
        data_in = 32'h3333_0002;
        tick();
        enable  = 1'b0;
        select  = 2'd0;
        data_in = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL en0_in_ready: got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (valid_0 !== 1'b0) begin
            n_err++;
            $display("FAIL en0_no_accept: got valid_0 %b want 0", valid_0);
        end
        ready_3 = 1'b1;
        n_cmp++;
        if (data_3 !== 32'h3333_0001) begin
            n_err++;
            $display("FAIL en0_drain1: got %h want 33330001", data_3);
        end
        tick();
        n_cmp++;
        if (data_3 !== 32'h3333_0002) begin
            n_err++;
            $display("FAIL en0_drain2: got %h want 33330002", data_3);
        end
        tick();
        n_cmp++;
        if (vout !== 4'b0000) begin
            n_err++;
            $display("FAIL en0_empty: got %b want 0000", vout);
        end
        in_valid = 1'b0;
        ready_3  = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic test_reset_flush();
        apply_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            select  = 2'(k);
            data_in = 32'h4000_0000 + 32'(k);
            tick();
        end
        n_cmp++;
        if (vout !== 4'b1111) begin
            n_err++;
            $display("FAIL flush_filled: got %b want 1111", vout);
        end
        reset   = 1'b1;
        ready_0 = 1'b1;
        select  = 2'd1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        ready_0  = 1'b0;
        #1;
        n_cmp++;
        if (vout !== 4'b0000 || (data_0 | data_1 | data_2 | data_3) !== 32'h0) begin
            n_err++;
            $display("FAIL flush_cleared: got %b %h %h %h %h want 0000 zeros", vout, data_0, data_1, data_2, data_3);
        end
        select   = 2'd1;
        data_in  = 32'h5555_AAAA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (vout !== 4'b0010 || data_1 !== 32'h5555_AAAA) begin
            n_err++;
            $display("FAIL flush_repush: got %b/%h want 0010/5555aaaa", vout, data_1);
        end
    endtask

    task automatic test_random();
        logic [31:0] q [4][$];
        logic [31:0] seq;
        logic [3:0]  rdy;
        logic        exp_ready;
        logic [31:0] exp_data;
        int          errs_before;
        apply_reset();
        seq = 32'h0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            errs_before = n_err;
            rdy      = 4'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 7) != 0);
            in_valid = $urandom_range(0, 1);
            select   = 2'($urandom_range(0, 3));
            data_in  = seq;
            {ready_3, ready_2, ready_1, ready_0} = rdy;
            #1;
            exp_ready = enable && (q[select].size() < 2);
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_err++;
                $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_ready);
            end
            for (int k = 0; k < 4; k++) begin
                exp_data = (q[k].size() != 0) ? q[k][0] : 32'h0;
                n_cmp++;
                if (vout[k] !== (q[k].size() != 0) || dout[k] !== exp_data) begin
                    n_err++;
                    $display("FAIL rnd_ch%0d cyc %0d: got %b/%h want %b/%h", k, cyc, vout[k], dout[k], (q[k].size() != 0), exp_data);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (rdy[k] && q[k].size() != 0) begin
                    void'(q[k].pop_front());
                end
            end
            if (in_valid && exp_ready) begin
                q[select].push_back(seq);
                seq = seq + 32'h1;
            end
            tick();
            if (n_err - errs_before > 0 && n_err > 20) begin
                break;
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_push();
        test_backpressure();
        test_push_pop_same();
        test_enable_low();
        test_reset_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_4_32_buf.md
DEMUX_4_32_BUF -- requirements
Module: demux_4_32_buf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data word width.
REQ-003 The block SHALL have parameter DEPTH, default 2, giving the per-channel buffer depth in words; the only legal value is a power of two of at least 2.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 data_in  input  WIDTH  word to distribute.
REQ-007 select  input  2  destination channel index, 0..3.
REQ-008 enable  input  1  block enable; when low, no word SHALL be accepted.
REQ-009 in_valid  input  1  data_in and select are valid this cycle.
REQ-010 in_ready  output  1  the block can accept the offered word.
REQ-011 data_0, data_1, data_2, data_3  output  WIDTH each  head word of channel k.
REQ-012 valid_0, valid_1, valid_2, valid_3  output  1 each  channel k holds at least one word.
REQ-013 ready_0, ready_1, ready_2, ready_3  input  1 each  the consumer of channel k takes the head word.

Function
REQ-014 Accept rule: in_ready SHALL equal enable AND NOT full[select].
REQ-015 A word SHALL be accepted when in_valid AND in_ready are high at a rising clock edge; it SHALL be pushed into channel select only.
REQ-016 No combinational path SHALL exist from any ready_k to in_ready.
REQ-017 Each channel SHALL be a DEPTH-entry FIFO with a per-channel count from 0 to DEPTH.
REQ-018 full_k SHALL mean count equals DEPTH; valid_k SHALL mean count is nonzero.
REQ-019 Latency: a word accepted at edge N SHALL appear on data_k with valid_k high after edge N, provided channel k was empty before edge N.
REQ-020 Pop: when valid_k AND ready_k are high at an edge, the head word of channel k SHALL be removed.
REQ-021 ready_k SHALL be ignored while valid_k is low.
REQ-022 Simultaneous push and pop on the same channel SHALL leave its count unchanged and preserve FIFO order.
REQ-023 When full, a channel SHALL accept a push only on a later cycle, never on the same cycle it pops.
REQ-024 Pushes to one channel SHALL never alter another channel's state.
REQ-025 Order SHALL be preserved within a channel; no ordering guarantee SHALL exist across channels.
REQ-026 data_k SHALL be all zeros while valid_k is low.
REQ-027 When enable is low, channels SHALL continue to drain, and their contents and outputs SHALL otherwise be unaffected.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Overflow and underflow SHALL be impossible by construction.

Reset
REQ-030 On reset, all counts and pointers SHALL be 0, valid_k SHALL be 0, data_k SHALL be 0, and in_ready SHALL be 0 during the reset cycle.
REQ-031 Reset SHALL take priority over a simultaneous push or pop; words in flight SHALL be discarded.
REQ-032 In the first cycle after reset deasserts, in_ready SHALL equal enable.

Structure
REQ-033 The shared package SHALL hold WIDTH_DEFAULT = 32, DEPTH_DEFAULT = 2 and N_CH = 4.
REQ-034 The per-channel FIFO SHALL be a single sub-module, demux_chan_fifo, instantiated four times.
REQ-035 demux_chan_fifo SHALL have ports clock, reset, push, push_data, pop, count, head, full and empty.
REQ-036 The top level SHALL contain only push decode, in_ready logic and output gating.

Verification
REQ-037 Reset, then enable=1, push 32'hA5A5_0001 with select=2, ready_2=0 -> valid_2=1 and data_2=32'hA5A5_0001 one cycle later; valid_0, valid_1 and valid_3 stay 0.
REQ-038 Push 3 words to channel 1 with ready_1=0 -> in_ready drops after the 2nd word; raising ready_1 pops the words in order, and in_ready returns the cycle after the first pop.
REQ-039 Channel 0 holds 1 word; push and pop channel 0 in the same cycle -> count stays 1 and the new word is the next head.
REQ-040 Channel 3 is full and enable=0, with select=0 and in_valid=1 -> in_ready=0 and nothing is accepted; ready_3=1 still drains channel 3.
REQ-041 Assert reset with all channels holding words -> after the reset edge all valid_k=0 and all data_k=0; a subsequent push works normally.
REQ-042 Random select, in_valid and ready_k for 10k cycles against a 4-queue scoreboard -> no loss, no duplication, per-channel order preserved, and in_ready always matches REQ-014.
